inst_queue: RTL and testbench

- Dual-slot instruction buffer between the fetch pipeline (F3 output) and the decode/issue stage.
- Absorbs fetch bursts and decouples fetch from issue stalls.
- Produces the `overflow` back-pressure signal used by the hazard unit to stall fetch.
- Consumes the hazard unit's queue-flush and issue-stall controls.

---
 rtl/inst_queue.sv | 111 +++++++++++
 tb/tb_inst_queue.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Dual-slot instruction queue between fetch (F3) and decode/issue.
// Circular buffer with first-word fall-through view of head and head+1.
module inst_queue #(
  parameter int DEPTH      = 16,
  parameter int OVF_MARGIN = 4,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic [1:0]       push_valid,
  input  logic [31:0]      push_pc0,
  input  logic [31:0]      push_instr0,
  input  logic [31:0]      push_pc1,
  input  logic [31:0]      push_instr1,
  input  logic [1:0]       pop_cnt,
  output logic [1:0]       out_valid,
  output logic [31:0]      out_pc0,
  output logic [31:0]      out_instr0,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_instr1,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic             err_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] OVF_C   = CNT_W'(OVF_MARGIN);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W+1)'(DEPTH);

  logic [31:0]      r_mem_pc    [DEPTH];
  logic [31:0]      r_mem_instr [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err_ovf;

  logic [1:0]       w_npop;
  logic [1:0]       w_npush;
  logic [1:0]       w_nwr;
  logic [CNT_W:0]   w_space;
  logic             w_drop;
  logic [PTR_W-1:0] w_head_p1;
  logic [PTR_W-1:0] w_tail_p1;
  logic [31:0]      w_first_pc;
  logic [31:0]      w_first_instr;

  assign w_head_p1 = r_head + PTR_W'(1);
  assign w_tail_p1 = r_tail + PTR_W'(1);

  always_comb begin
    w_npop = '0;
    if (!stall)
      w_npop = (CNT_W'(pop_cnt) > r_count) ? r_count[1:0] : pop_cnt;
  end

  // Same-cycle pops free space for pushes; excess entries drop entry1 first.
  always_comb begin
    w_npush = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
    w_space = DEPTH_X - {1'b0, r_count} + (CNT_W+1)'(w_npop);
    w_nwr   = (w_space < (CNT_W+1)'(w_npush)) ? w_space[1:0] : w_npush;
    w_drop  = (w_nwr != w_npush);
  end

  // First written entry is entry0 when valid, otherwise entry1.
  assign w_first_pc    = push_valid[0] ? push_pc0    : push_pc1;
  assign w_first_instr = push_valid[0] ? push_instr0 : push_instr1;

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (w_nwr != 2'd0) begin
        r_mem_pc[r_tail]    <= w_first_pc;
        r_mem_instr[r_tail] <= w_first_instr;
      end
      if (w_nwr == 2'd2) begin
        r_mem_pc[w_tail_p1]    <= push_pc1;
        r_mem_instr[w_tail_p1] <= push_instr1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
    end else if (flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_npop);
      r_tail  <= r_tail + PTR_W'(w_nwr);
      r_count <= r_count + CNT_W'(w_nwr) - CNT_W'(w_npop);
      if (w_drop)
        r_err_ovf <= 1'b1;
    end
  end

  assign out_valid  = flush ? 2'b00 : {(r_count >= CNT_W'(2)), (r_count != '0)};
  assign out_pc0    = r_mem_pc[r_head];
  assign out_instr0 = r_mem_instr[r_head];
  assign out_pc1    = r_mem_pc[w_head_p1];
  assign out_instr1 = r_mem_instr[w_head_p1];
  assign overflow   = (DEPTH_C - r_count) <= OVF_C;
  assign count      = r_count;
  assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue (DEPTH=16, OVF_MARGIN=4).
module tb_inst_queue;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset, flush, stall;
  logic [1:0]       push_valid, pop_cnt;
  logic [31:0]      push_pc0, push_instr0, push_pc1, push_instr1;
  logic [1:0]       out_valid;
  logic [31:0]      out_pc0, out_instr0, out_pc1, out_instr1;
  logic             overflow, err_ovf;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(DEPTH), .OVF_MARGIN(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .push_valid(push_valid),
    .push_pc0(push_pc0), .push_instr0(push_instr0),
    .push_pc1(push_pc1), .push_instr1(push_instr1),
    .pop_cnt(pop_cnt),
    .out_valid(out_valid),
    .out_pc0(out_pc0), .out_instr0(out_instr0),
    .out_pc1(out_pc1), .out_instr1(out_instr1),
    .overflow(overflow), .count(count), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, stall;
    logic [1:0]  pv;
    logic [31:0] pc0, pc1;
    logic [1:0]  pop;
    logic [1:0]  e_ov;
    logic [31:0] e_pc0, e_pc1;
    int          e_cnt;
    logic        e_ovf, e_err;
  } vec_t;

  function automatic vec_t v(logic fl, logic st, logic [1:0] pv, logic [31:0] pc0,
                             logic [31:0] pc1, logic [1:0] pop, logic [1:0] e_ov,
                             logic [31:0] e_pc0, logic [31:0] e_pc1, int e_cnt,
                             logic e_ovf, logic e_err);
    vec_t r;
    r.flush = fl; r.stall = st; r.pv = pv; r.pc0 = pc0; r.pc1 = pc1; r.pop = pop;
    r.e_ov = e_ov; r.e_pc0 = e_pc0; r.e_pc1 = e_pc1; r.e_cnt = e_cnt;
    r.e_ovf = e_ovf; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic st, logic [1:0] pv, logic [31:0] pc0,
                       logic [31:0] pc1, logic [1:0] pop);
    flush = fl; stall = st; push_valid = pv; pop_cnt = pop;
    push_pc0 = pc0; push_instr0 = ~pc0;
    push_pc1 = pc1; push_instr1 = ~pc1;
  endtask

  // Drive one cycle of inputs, then compare registered outputs #1 after the edge.
  task automatic apply(vec_t x, int id);
    drive(x.flush, x.stall, x.pv, x.pc0, x.pc1, x.pop);
    @(posedge clk);
    #1;
    chk("out_valid", id, 32'(out_valid), 32'(x.e_ov));
    chk("count",     id, 32'(count),     32'(x.e_cnt));
    chk("overflow",  id, 32'(overflow),  32'(x.e_ovf));
    chk("err_ovf",   id, 32'(err_ovf),   32'(x.e_err));
    if (x.e_ov[0]) begin
      chk("out_pc0",    id, out_pc0,    x.e_pc0);
      chk("out_instr0", id, out_instr0, ~x.e_pc0);
    end
    if (x.e_ov[1]) begin
      chk("out_pc1",    id, out_pc1,    x.e_pc1);
      chk("out_instr1", id, out_instr1, ~x.e_pc1);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // Fill, overflow threshold, drop at full, drain, stall-with-push.
    tbl.push_back(v(0,0,2'b11,32'h1000,32'h1004,0, 2'b11,32'h1000,32'h1004, 2,0,0));
    tbl.push_back(v(0,0,2'b11,32'h1008,32'h100C,0, 2'b11,32'h1000,32'h1004, 4,0,0));
    tbl.push_back(v(0,0,2'b11,32'h1010,32'h1014,0, 2'b11,32'h1000,32'h1004, 6,0,0));
    tbl.push_back(v(0,0,2'b11,32'h1018,32'h101C,0, 2'b11,32'h1000,32'h1004, 8,0,0));
    tbl.push_back(v(0,0,2'b11,32'h1020,32'h1024,0, 2'b11,32'h1000,32'h1004,10,0,0));
    tbl.push_back(v(0,0,2'b01,32'h1028,32'h0,   0, 2'b11,32'h1000,32'h1004,11,0,0));
    tbl.push_back(v(0,0,2'b01,32'h102C,32'h0,   0, 2'b11,32'h1000,32'h1004,12,1,0));
    tbl.push_back(v(0,0,2'b11,32'h1030,32'h1034,0, 2'b11,32'h1000,32'h1004,14,1,0));
    tbl.push_back(v(0,0,2'b11,32'h1038,32'h103C,0, 2'b11,32'h1000,32'h1004,16,1,0));
    tbl.push_back(v(0,0,2'b11,32'h1040,32'h1044,1, 2'b11,32'h1004,32'h1008,16,1,1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0,0,2'b00,32'h0,32'h0,0, 2'b11,32'h1004,32'h1008,16,1,1));
    tbl.push_back(v(0,0,2'b00,32'h0,32'h0,2, 2'b11,32'h100C,32'h1010,14,1,1));
    tbl.push_back(v(0,0,2'b00,32'h0,32'h0,2, 2'b11,32'h1014,32'h1018,12,1,1));
    tbl.push_back(v(0,0,2'b00,32'h0,32'h0,2, 2'b11,32'h101C,32'h1020,10,0,1));
    tbl.push_back(v(0,0,2'b00,32'h0,32'h0,2, 2'b11,32'h1024,32'h1028, 8,0,1));
    tbl.push_back(v(0,0,2'b00,32'h0,32'h0,2, 2'b11,32'h102C,32'h1030, 6,0,1));
    tbl.push_back(v(0,0,2'b00,32'h0,32'h0,1, 2'b11,32'h1030,32'h1034, 5,0,1));
    tbl.push_back(v(0,1,2'b01,32'h3000,32'h0,2, 2'b11,32'h1030,32'h1034, 6,0,1));
    tbl.push_back(v(0,0,2'b01,32'h3004,32'h0,0, 2'b11,32'h1030,32'h1034, 7,0,1));

    reset = 1'b1;
    drive(0, 0, 2'b00, 32'h0, 32'h0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_count",     0, 32'(count),     32'h0);
    chk("rst_overflow",  0, 32'(overflow),  32'h0);
    chk("rst_err_ovf",   0, 32'(err_ovf),   32'h0);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i + 1);

    // Flush with concurrent push/pop: valids drop in the flush cycle itself.
    drive(1, 0, 2'b11, 32'h9000, 32'h9004, 2'd2);
    #1;
    chk("flush_cycle_valid", 100, 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("flush_count",    101, 32'(count),     32'h0);
    chk("flush_valid",    101, 32'(out_valid), 32'h0);
    chk("flush_overflow", 101, 32'(overflow),  32'h0);
    chk("flush_err_ovf",  101, 32'(err_ovf),   32'h1);
    apply(v(0,0,2'b01,32'h4000,32'h0,0, 2'b01,32'h4000,32'h0,1,0,1), 102);
    // pop_cnt above count is clamped
    apply(v(0,0,2'b00,32'h0,32'h0,2, 2'b00,32'h0,32'h0,0,0,1), 103);

    // Walk head/tail (both at 4) up to index 15, then straddle the wrap.
    for (int k = 0; k < 11; k++)
      apply(v(0,0,2'b01,32'h6000 + 32'(4*k),32'h0,1,
              2'b01,32'h6000 + 32'(4*k),32'h0,1,0,1), 110 + k);
    apply(v(0,0,2'b00,32'h0,32'h0,1, 2'b00,32'h0,32'h0,0,0,1), 130);
    apply(v(0,0,2'b11,32'h2000,32'h2004,0, 2'b11,32'h2000,32'h2004,2,0,1), 131);
    apply(v(0,0,2'b00,32'h0,32'h0,2, 2'b00,32'h0,32'h0,0,0,1), 132);
    // push_valid=10 writes entry1 alone
    apply(v(0,0,2'b10,32'h7777,32'h5000,0, 2'b01,32'h5000,32'h0,1,0,1), 133);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
